transmitter: RTL and testbench

Serial transmit half of the UART: accepts a byte from the bus side through a one-entry holding buffer and shifts it out on `txd` as 8N1 (start bit, 8 data bits LSB first, one stop bit). Bit timing comes from the shared oversampling tick, the same one the receive side uses, so each bit spans `OVERSAMPLE` ticks. The holding buffer plus shift register allows back-to-back frames with no idle gap between them.

---
 rtl/transmitter.sv | 118 +++++++++++
 tb/tb_transmitter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/transmitter.sv
// Purpose: 8N1 UART transmit path; one-entry holding register feeding a shift register clocked by oversampling ticks.
// Latency: a byte loaded while idle starts its frame (txd falls) on the next clk edge; a frame lasts 10*OVERSAMPLE ticks.
// Backpressure: tbr=0 while the holding register is full; a tx_load seen with tbr=0 is dropped silently.
// Ports: clk/rst (async active-low) | t_enable tick | tx_load/tx_data byte in | txd line, tbr buffer empty, tx_busy frame active.
module transmitter #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       t_enable,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tbr,
    output logic       tx_busy
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TLAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_nxt;
    logic [7:0]     hr, sr, sr_nxt;
    logic           full, full_nxt;
    logic [TW-1:0]  tcnt, tcnt_nxt;
    logic [2:0]     bitcnt, bitcnt_nxt;
    logic           txd_nxt;
    logic           bit_end;
    logic           take;

    always_comb begin
        state_nxt  = state;
        sr_nxt     = sr;
        tcnt_nxt   = tcnt;
        bitcnt_nxt = bitcnt;
        txd_nxt    = txd;
        take       = 1'b0;
        bit_end    = (state != IDLE) && t_enable && (tcnt == TLAST);

        if ((state != IDLE) && t_enable)
            tcnt_nxt = bit_end ? '0 : tcnt + TW'(1);

        case (state)
            IDLE: begin
                txd_nxt = 1'b1;
                // Hand-off from the holding register does not wait for a tick.
                if (full)
                    take = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_nxt  = DATA;
                    bitcnt_nxt = 3'd0;
                    txd_nxt    = sr[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bitcnt == 3'd7) begin
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
                    end else begin
                        bitcnt_nxt = bitcnt + 3'd1;
                        txd_nxt    = sr[bitcnt + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    // A waiting byte starts its START bit on the very edge the stop bit ends.
                    if (full) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        txd_nxt   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (take) begin
            state_nxt = START;
            sr_nxt    = hr;
            tcnt_nxt  = '0;
            txd_nxt   = 1'b0;
        end

        // take only happens with full=1, a load only lands with full=0, so they never collide.
        full_nxt = take ? 1'b0 : (full | tx_load);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            hr     <= 8'd0;
            sr     <= 8'd0;
            full   <= 1'b0;
            tcnt   <= '0;
            bitcnt <= 3'd0;
            txd    <= 1'b1;
        end else begin
            state  <= state_nxt;
            sr     <= sr_nxt;
            full   <= full_nxt;
            tcnt   <= tcnt_nxt;
            bitcnt <= bitcnt_nxt;
            txd    <= txd_nxt;
            if (tx_load && !full)
                hr <= tx_data;
        end
    end

    assign tbr     = !full;
    assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_transmitter.sv
// Purpose: randomized bench for transmitter with a tick-count reference model and a frame-decoding monitor.
// Latency: model predicts acceptance, buffer state and remaining frame ticks every clk edge.
// Backpressure: loads refused by the model's buffer are not expected on the line.
module tb_transmitter;

    localparam int OS = 16;

    logic       clk;
    logic       rst;
    logic       t_enable;
    logic       tx_load;
    logic [7:0] tx_data;
    logic       txd;
    logic       tbr;
    logic       tx_busy;

    logic       ld2;
    logic [7:0] dat2;
    logic       txd2;
    logic       tbr2;
    logic       busy2;

    transmitter #(.OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .t_enable(t_enable), .tx_load(tx_load),
        .tx_data(tx_data), .txd(txd), .tbr(tbr), .tx_busy(tx_busy)
    );

    transmitter #(.OVERSAMPLE(2)) dut2 (
        .clk(clk), .rst(rst), .t_enable(1'b1), .tx_load(ld2),
        .tx_data(dat2), .txd(txd2), .tbr(tbr2), .tx_busy(busy2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model (buffer flag + ticks left in frame) -------------
    logic [7:0] exp_q[$];
    bit  m_full = 1'b0;
    int  m_rem  = 0;
    bit  last_ten = 1'b0;
    bit  acc, xfer;

    always @(posedge clk) begin
        last_ten = t_enable;
        if (!rst) begin
            m_full = 1'b0;
            m_rem  = 0;
        end else begin
            acc  = tx_load && !m_full;
            xfer = 1'b0;
            if (m_rem == 0) begin
                xfer = m_full;
            end else if (t_enable) begin
                m_rem--;
                if (m_rem == 0) xfer = m_full;
            end
            if (xfer) m_rem = 10 * OS;
            m_full = (m_full && !xfer) || acc;
            if (acc) exp_q.push_back(tx_data);
        end
    end

    // ---------------- monitor: decode frames from txd, compare with scoreboard -------
    bit         in_frame = 1'b0;
    int         ticks = 0;
    int         mism  = 0;
    logic [7:0] dec, cur_b;

    always @(negedge clk) begin
        if (!rst) begin
            in_frame = 1'b0;
            exp_q.delete();
            chk("reset_txd", int'(txd), 1);
            chk("reset_tbr", int'(tbr), 1);
            chk("reset_busy", int'(tx_busy), 0);
        end else begin
            if (in_frame && last_ten) ticks++;
            if (in_frame && ticks == 10 * OS) begin
                chk("frame_byte", int'(dec), int'(cur_b));
                chk("frame_shape", mism, 0);
                in_frame = 1'b0;
            end
            if (!in_frame && txd == 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    cur_b = 8'h00;
                end else begin
                    cur_b = exp_q.pop_front();
                end
                chk("start_timing", m_rem, 10 * OS);
                in_frame = 1'b1;
                ticks = 0;
                mism  = 0;
                dec   = 8'h00;
            end
            if (in_frame) begin
                if (txd != fbit(cur_b, ticks / OS)) mism++;
                if ((ticks % OS) == OS / 2 && ticks / OS >= 1 && ticks / OS <= 8)
                    dec[ticks / OS - 1] = txd;
            end
            chk("tbr", int'(tbr), int'(!m_full));
            chk("busy", int'(tx_busy), int'(m_rem != 0));
        end
    end

    // ---------------- tick generator ---------------------------------------------------
    int ten_mode = 2;
    int cyc = 0;

    initial begin
        t_enable = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            case (ten_mode)
                0:       t_enable = 1'b1;
                1:       t_enable = (cyc % 4 == 0);
                default: t_enable = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic do_load(input logic [7:0] b);
        @(posedge clk);
        #2;
        tx_load = 1'b1;
        tx_data = b;
        @(posedge clk);
        #2;
        tx_load = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // ---------------- stimulus ---------------------------------------------------------
    logic [9:0] f2;

    initial begin
        rst = 1'b0;
        tx_load = 1'b0;
        tx_data = 8'h00;
        ld2 = 1'b0;
        dat2 = 8'h00;
        repeat (12) begin
            @(posedge clk);
            #2;
            tx_load = 1'($urandom_range(0, 1));
            tx_data = 8'($urandom);
        end
        tx_load = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle(5);

        // OVERSAMPLE=2 build: 0x81 frame, 2 clocks per bit with tick tied high.
        f2 = {1'b1, 8'h81, 1'b0};
        @(posedge clk);
        #2;
        ld2 = 1'b1;
        dat2 = 8'h81;
        @(posedge clk);
        #2;
        ld2 = 1'b0;
        chk("os2_tbr_full", int'(tbr2), 0);
        @(posedge clk);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk("os2_txd", int'(txd2), int'(f2[j / 2]));
            @(posedge clk);
        end
        @(negedge clk);
        chk("os2_busy_end", int'(busy2), 0);
        chk("os2_txd_idle", int'(txd2), 1);

        // Tick tied high, 0xA5.
        ten_mode = 0;
        do_load(8'hA5);
        idle(200);

        // Tick every 4th clock, 0x3C.
        ten_mode = 1;
        do_load(8'h3C);
        idle(700);

        // Back-to-back: second byte lands during data bit 2 of the first.
        ten_mode = 0;
        do_load(8'h55);
        idle(50);
        do_load(8'h0F);
        idle(380);

        // Overrun: 0xFF arrives while the buffer already holds 0xC3.
        do_load(8'h6E);
        idle(20);
        do_load(8'hC3);
        idle(3);
        do_load(8'hFF);
        idle(400);

        // Reset in the middle of a frame.
        do_load(8'h99);
        idle(40);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_txd", int'(txd), 1);
        chk("midreset_busy", int'(tx_busy), 0);
        chk("midreset_tbr", int'(tbr), 1);
        idle(3);
        #2;
        rst = 1'b1;
        idle(200);

        // Randomized loads under varied tick patterns.
        for (int i = 0; i < 40; i++) begin
            ten_mode = $urandom_range(0, 2);
            do_load(8'($urandom));
            idle($urandom_range(0, 200));
        end
        ten_mode = 0;
        idle(400);
        chk("queue_empty", exp_q.size(), 0);
        chk("final_idle_txd", int'(txd), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
